// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: FSM state encoding and
// the fixed protocol constants used by the bit-stuffing serializer.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      STUFF,
      EOP,
      EOP_IDLE
   } tx_state_e;

   // Sync byte, sent LSB first as 0000_0001
   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   // Number of SE0 bit periods that make up end-of-packet
   localparam int         EOP_SE0_BITS = 2;
   // Consecutive ones that force a stuffed zero
   localparam int         STUFF_RUN    = 6;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, strobing on the
// last count. restart forces the count back to 0 so a new packet starts
// on a fresh, full-length bit period.
module tx_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_strobe
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap at the end of a bit period or on restart
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_strobe = (cnt_q == LAST);

endmodule

// File: rtl/tx_bitstuff_serializer.sv
// USB transmit serializer with bit stuffing. Bytes are taken from a
// one-deep holding register into a shift register and sent LSB first as
// raw bits for the downstream NRZI encoder. After six consecutive ones a
// zero is stuffed; a packet ends with two SE0 bit periods and one idle
// J bit period. Running out of bytes before the final one aborts the
// packet with an EOP and a one-cycle tx_underrun pulse.
// Build option: define SYNC_GEN_EN to have the block emit the sync byte
// itself ahead of the first payload byte; otherwise upstream sends it.
module tx_bitstuff_serializer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx_data,
   output logic       tx_eop,
   output logic       busy,
   output logic       tx_underrun
);

   localparam logic [2:0] STUFF_N  = 3'(STUFF_RUN);
   localparam logic [1:0] EOP_LAST = 2'(EOP_SE0_BITS - 1);

   // Run length of ones after sending bit b; saturates at the stuff threshold
   function automatic logic [2:0] next_ones(input logic [2:0] run, input logic b);
      if (!b) return 3'd0;
      if (run >= STUFF_N) return STUFF_N;
      return run + 3'd1;
   endfunction

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [2:0] ones_q, ones_d;
   logic       last_q, last_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_last_q, hold_last_d;
   logic       hold_full_q, hold_full_d;
   logic [1:0] eop_cnt_q, eop_cnt_d;
   logic       tx_data_q, tx_data_d;
   logic       tx_eop_q, tx_eop_d;
   logic       underrun_q, underrun_d;
   logic       rdy_en_q;

   logic       accept;
   logic       bit_strobe;
   logic       restart;
   logic       ld_en;
   logic [7:0] ld_byte;
   logic       ld_last;
   tx_state_e  ld_state;
   logic       eop_en;

   assign accept  = in_valid & in_ready;
   assign restart = (state_q == IDLE) & ld_en;

   tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .bit_strobe(bit_strobe)
   );

   // Next-state logic: byte intake, bit sequencing, stuffing and EOP framing
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      ones_d      = ones_q;
      last_d      = last_q;
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      hold_full_d = hold_full_q;
      eop_cnt_d   = eop_cnt_q;
      tx_data_d   = tx_data_q;
      tx_eop_d    = tx_eop_q;
      underrun_d  = 1'b0;
      ld_en       = 1'b0;
      ld_byte     = hold_q;
      ld_last     = hold_last_q;
      ld_state    = DATA;
      eop_en      = 1'b0;

      if (accept) begin
         hold_d      = in_data;
         hold_last_d = in_last;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            tx_data_d = 1'b1;
            tx_eop_d  = 1'b0;
`ifdef SYNC_GEN_EN
            // The first byte waits in the holding register behind the sync byte
            if (hold_full_q || accept) begin
               ld_en    = 1'b1;
               ld_byte  = SYNC_PATTERN;
               ld_last  = 1'b0;
               ld_state = SYNC;
            end
`else
            if (hold_full_q) begin
               ld_en       = 1'b1;
               hold_full_d = 1'b0;
            end else if (accept) begin
               // Pass straight through to the shift register
               ld_en       = 1'b1;
               ld_byte     = in_data;
               ld_last     = in_last;
               hold_full_d = 1'b0;
            end
`endif
         end
         SYNC, DATA, STUFF: begin
            if (bit_strobe) begin
               if ((state_q != STUFF) && (ones_q == STUFF_N)) begin
                  state_d   = STUFF;
                  tx_data_d = 1'b0;
                  ones_d    = 3'd0;
               end else if (bit_idx_q != 3'd7) begin
                  state_d   = (state_q == STUFF) ? DATA : state_q;
                  tx_data_d = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  ones_d    = next_ones(ones_q, shift_q[0]);
               end else if (last_q) begin
                  eop_en = 1'b1;
               end else if (hold_full_q) begin
                  ld_en       = 1'b1;
                  hold_full_d = 1'b0;
               end else begin
                  eop_en     = 1'b1;
                  underrun_d = 1'b1;
               end
            end
         end
         EOP: begin
            if (bit_strobe) begin
               if (eop_cnt_q == EOP_LAST) begin
                  state_d  = EOP_IDLE;
                  tx_eop_d = 1'b0;
                  tx_data_d = 1'b1;
               end else begin
                  eop_cnt_d = eop_cnt_q + 2'd1;
               end
            end
         end
         EOP_IDLE: begin
            if (bit_strobe) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ld_en) begin
         state_d   = ld_state;
         shift_d   = {1'b0, ld_byte[7:1]};
         tx_data_d = ld_byte[0];
         bit_idx_d = 3'd0;
         last_d    = ld_last;
         ones_d    = next_ones(ones_q, ld_byte[0]);
      end

      if (eop_en) begin
         state_d   = EOP;
         tx_data_d = 1'b1;
         tx_eop_d  = 1'b1;
         eop_cnt_d = 2'd0;
         ones_d    = 3'd0;
      end
   end

   // Control state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_idx_q   <= 3'd0;
         ones_q      <= 3'd0;
         hold_full_q <= 1'b0;
         eop_cnt_q   <= 2'd0;
         tx_data_q   <= 1'b1;
         tx_eop_q    <= 1'b0;
         underrun_q  <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         ones_q      <= ones_d;
         hold_full_q <= hold_full_d;
         eop_cnt_q   <= eop_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_eop_q    <= tx_eop_d;
         underrun_q  <= underrun_d;
         rdy_en_q    <= 1'b1;
      end
   end

   // Byte payload registers; only meaningful while their valid flags are set
   always_ff @(posedge clk) begin
      shift_q     <= shift_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
   end

   assign in_ready    = rdy_en_q & ~hold_full_q & ~rst;
   assign tx_data     = tx_data_q;
   assign tx_eop      = tx_eop_q;
   assign busy        = (state_q != IDLE);
   assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_tx_bitstuff_serializer.sv
// Scoreboard bench for tx_bitstuff_serializer. The stimulus process pushes
// the expected symbol stream of each packet ('0'/'1' data bits, 'E' for an
// SE0 period) plus the expected underrun pulse length; the monitor pops and
// checks every clock of every bit period once the DUT goes busy.
module tb_tx_bitstuff_serializer;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx_data;
   logic       tx_eop;
   logic       busy;
   logic       tx_underrun;

   int  n_vec = 0;
   int  n_err = 0;
   byte exp_q[$];
   int  len_q[$];
   int  urun_q[$];
   bit  mon_busy = 1'b0;

   always #5 clk = ~clk;

   tx_bitstuff_serializer #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_data    (tx_data),
      .tx_eop     (tx_eop),
      .busy       (busy),
      .tx_underrun(tx_underrun)
   );

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_pkt(input string bits, input int urun);
      for (int i = 0; i < bits.len(); i++) exp_q.push_back(bits[i]);
      len_q.push_back(bits.len());
      urun_q.push_back(urun);
   endtask

   // Offer one byte; returns one step after the accepting edge
   task automatic send_byte(input logic [7:0] d, input logic last);
      int k;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: byte %h never accepted, in_ready=%b", d, in_ready);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (len_q.size() == 0 && !mon_busy) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: %0d packets still pending, required 0", len_q.size());
   endtask

   // Monitor: compare each bit period of a packet against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && !rst) begin : pkt
            int  len;
            int  urun_exp;
            int  urun_cnt;
            bit  aborted;
            mon_busy = 1'b1;
            if (len_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_packet: busy=1, required no packet");
               for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
            end else begin
               len      = len_q.pop_front();
               urun_exp = urun_q.pop_front();
               urun_cnt = 0;
               aborted  = 1'b0;
               for (int i = 0; i < len; i++) begin : sym
                  byte  s;
                  bit   bad;
                  logic ad;
                  logic ae;
                  s   = exp_q.pop_front();
                  bad = 1'b0;
                  ad  = 1'b0;
                  ae  = 1'b0;
                  if (!aborted) begin
                     for (int c = 0; c < N; c++) begin
                        if (rst) begin
                           aborted = 1'b1;
                           break;
                        end
                        if (tx_underrun === 1'b1) urun_cnt++;
                        if (!bad && ((s == "E") ? (tx_eop !== 1'b1)
                                     : (tx_eop !== 1'b0 || tx_data !== (s == "1")))) begin
                           bad = 1'b1;
                           ad  = tx_data;
                           ae  = tx_eop;
                        end
                        @(negedge clk);
                     end
                     if (!aborted) begin
                        n_vec++;
                        if (bad) begin
                           n_err++;
                           $display("FAIL symbol[%0d]: tx_data=%b tx_eop=%b, required symbol %s",
                                    i, ad, ae, string'(s));
                        end
                     end
                  end
               end
               if (!aborted) begin
                  check("busy_after_packet", int'(busy), 0);
                  check("underrun_cycles", urun_cnt, urun_exp);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      string sp;
`ifdef SYNC_GEN_EN
      sp = "00000001";
`else
      sp = "";
`endif

      // Reset: three cycles high
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", int'(tx_data), 1);
      check("rst_tx_eop", int'(tx_eop), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_underrun", int'(tx_underrun), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_release", int'(in_ready), 1);
      @(posedge clk); #1;

      // 0x00 single-byte packet
      push_pkt({sp, "00000000", "EE1"}, 0);
      send_byte(8'h00, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // 0xFF 0xFF: two stuffed zeros
`ifdef SYNC_GEN_EN
      push_pkt({sp, "111110111111011111", "EE1"}, 0);
`else
      push_pkt({sp, "111111011111101111", "EE1"}, 0);
`endif
      send_byte(8'hFF, 1'b0);
      send_byte(8'hFF, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // 0x3F single byte
`ifdef SYNC_GEN_EN
      push_pkt({sp, "111110100", "EE1"}, 0);
`else
      push_pkt({sp, "111111000", "EE1"}, 0);
`endif
      send_byte(8'h3F, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // Last byte ends in six ones: stuff before EOP
      push_pkt({sp, "001111110", "EE1"}, 0);
      send_byte(8'hFC, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // Two bytes, run of ones spans the boundary
      push_pkt({sp, "10100101", "011111100", "EE1"}, 0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h7E, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // Underrun: no final byte
      push_pkt({sp, "01001000", "EE1"}, 1);
      send_byte(8'h12, 1'b0);
      wait_done();
      @(posedge clk); #1;

      // Back-to-back packets: second byte buffered while the first drains
      push_pkt({sp, "10000000", "EE1"}, 0);
      push_pkt({sp, "10101010", "EE1"}, 0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h55, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // Reset during the third bit period; buffered byte must be discarded
      push_pkt({sp, "01011010", "EE1"}, 0);
      send_byte(8'h5A, 1'b0);
`ifdef SYNC_GEN_EN
      repeat (2 * N + 2) begin @(posedge clk); #1; end
`else
      send_byte(8'hFF, 1'b0);
      repeat (2 * N + 1) begin @(posedge clk); #1; end
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_tx_data", int'(tx_data), 1);
      check("abort_tx_eop", int'(tx_eop), 0);
      check("abort_busy", int'(busy), 0);
      begin : quiet
         int seen;
         seen = 0;
         for (int k = 0; k < 4 * N; k++) begin
            @(negedge clk);
            if (tx_eop !== 1'b0 || busy !== 1'b0 || tx_data !== 1'b1) seen++;
         end
         check("no_eop_after_abort", seen, 0);
      end
      check("ready_after_abort", int'(in_ready), 1);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tx_bitstuff_serializer.md
TX_BITSTUFF_SERIALIZER -- requirements
Module: tx_bitstuff_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per USB bit period (integer >= 2).
REQ-002 SHALL have port clk, input, 1, the single block clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8, the packet byte to send, transmitted LSB first.
REQ-005 SHALL have port in_last, input, 1, marks in_data as the final byte of the packet.
REQ-006 SHALL have port in_valid, input, 1, byte offer from upstream.
REQ-007 SHALL have port in_ready, output, 1, holding register empty; a byte is accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port tx_data, output, 1, raw stuffed bit to the NRZI encoder; idle level is 1.
REQ-009 SHALL have port tx_eop, output, 1, SE0 request to the NRZI encoder.
REQ-010 SHALL have port busy, output, 1, packet in progress.
REQ-011 SHALL have port tx_underrun, output, 1, one-cycle pulse on a starved abort.

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, DATA, STUFF, EOP, EOP_IDLE.
REQ-013 SHALL run a bit timer that counts 0..CLKS_PER_BIT-1 and wraps; tx_data and tx_eop change only on the cycle after the timer wraps, except on the first SYNC or DATA bit.
REQ-014 SHALL buffer one byte in a holding register plus an 8-bit shift register; in_ready = ~holding_full, and a shift-register load frees the holding register in the same cycle.
REQ-015 SHALL leave IDLE on byte acceptance, with the first bit on tx_data in the cycle after acceptance and the bit timer restarting from 0.
REQ-016 SHALL keep a ones counter, 0..6, that counts consecutive 1 bits across byte boundaries and clears on any 0 bit, including a stuff bit.
REQ-017 SHALL, when the ones counter reaches 6, enter STUFF for one bit period with tx_data = 0 and then resume with the next payload bit; this also applies after the final payload bit, before EOP.
REQ-018 SHALL, at the end of each byte, reload from the holding register if it is full; if the byte had in_last set, it SHALL go to EOP.
REQ-019 SHALL, at a byte boundary with the holding register empty and in_last not yet seen, go to EOP and pulse tx_underrun high for 1 cycle.
REQ-020 SHALL, in EOP, drive tx_eop = 1 for exactly 2 bit periods; in EOP_IDLE it SHALL drive tx_data = 1 and tx_eop = 0 for 1 bit period, then enter IDLE.
REQ-021 SHALL assert busy in every state except IDLE.
REQ-022 SHALL let in_ready accept the next packet's first byte during EOP or EOP_IDLE; that packet starts only after IDLE is reached.
REQ-023 SHALL hold tx_data = 1 and tx_eop = 0 in IDLE.

Reset
REQ-024 SHALL, while rst = 1, force: state IDLE, all counters 0, holding register empty, tx_data = 1, tx_eop = 0, busy = 0, tx_underrun = 0, in_ready = 0.
REQ-025 SHALL raise in_ready to 1 on the first cycle after rst is released.
REQ-026 SHALL, on reset mid-packet, abort with no EOP and discard buffered bytes; reset takes priority over all other events.

Configuration
REQ-027 SHALL, with SYNC_GEN_EN defined, enter SYNC on the first accepted byte and send 8'h80 LSB first (0000_0001) before the payload; the SYNC bits feed the ones counter.
REQ-028 SHALL, without SYNC_GEN_EN, omit the SYNC state and send the first accepted byte directly; upstream then supplies SYNC as data.

Structure
REQ-029 SHALL take the state enum, SYNC_PATTERN = 8'h80, EOP_SE0_BITS = 2 and STUFF_RUN = 6 from the shared package usb_tx_pkg.
REQ-030 SHALL implement the bit timer as sub-module tx_bit_timer (parameter CLKS_PER_BIT, inputs clk/rst/restart, output bit_strobe).

Verification
REQ-031 SHALL cover reset: rst = 1 for 3 cycles -> tx_data = 1, tx_eop = 0, busy = 0; in_ready = 1 one cycle after release.
REQ-032 SHALL cover SYNC_GEN_EN with 8'h00, last -> bits 0000_0001 then 0000_0000, then tx_eop high for 16 clocks, then tx_data = 1 for 8 clocks, then busy = 0.
REQ-033 SHALL cover SYNC_GEN_EN with 8'hFF then 8'hFF, last -> stuff 0 after the 5th and the 11th payload 1, giving 26 bit periods before EOP.
REQ-034 SHALL cover no SYNC_GEN_EN with 8'h3F, last -> bits 1,1,1,1,1,1,0(stuff),0,0, giving 9 bit periods, then EOP.
REQ-035 SHALL cover 8'h12 with last = 0 and no further byte -> EOP after the 8th bit and tx_underrun high for exactly 1 cycle.
REQ-036 SHALL cover rst = 1 for 1 cycle at the 3rd bit of a byte -> tx_data = 1 and tx_eop = 0 the next cycle, with no EOP emitted.
